// File: rtl/danger_spawner.sv
// danger_spawner: spawns obstacles at the right screen edge into three slots,
// scrolls them left by speed+1 pixels per game tick and retires them once
// they reach the left edge.
// Optional feature macro: DANGER_BIRD_EN (when undefined, bird types are
// remapped so only cactus types 2..4 are produced).
module danger_spawner #(
   parameter logic [8:0]  SPAWN_X = 9'd397,
   parameter logic [7:0]  MIN_GAP = 8'd24,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       run,
   input  logic       clear,
   input  logic [2:0] speed,
   output logic [8:0] danger_pos1,
   output logic [8:0] danger_pos2,
   output logic [8:0] danger_pos3,
   output logic [2:0] danger_type1,
   output logic [2:0] danger_type2,
   output logic [2:0] danger_type3,
   output logic       danger_en1,
   output logic       danger_en2,
   output logic       danger_en3
);

   localparam logic [2:0] T_NOTHING = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [8:0]  pos_q  [3];
   logic [8:0]  pos_d  [3];
   logic [2:0]  type_q [3];
   logic [2:0]  type_d [3];
   logic        en_q   [3];
   logic        en_d   [3];
   logic [7:0]  gap_q, gap_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [3:0]  step;
   logic        found;

   // LFSR low bits to obstacle type; birds folded onto cacti unless enabled
   function automatic logic [2:0] map_type(input logic [2:0] v);
      logic [2:0] r;
      case (v)
`ifdef DANGER_BIRD_EN
         3'd0:    r = 3'd0;
         3'd1:    r = 3'd1;
`else
         3'd0:    r = 3'd2;
         3'd1:    r = 3'd4;
`endif
         3'd5:    r = 3'd2;
         3'd6:    r = 3'd3;
         3'd7:    r = 3'd4;
         default: r = v;
      endcase
      return r;
   endfunction

   // Gap reload sum is formed in 9 bits and clipped to the 8-bit counter
   function automatic logic [7:0] sat_gap(input logic [8:0] s);
      return (s > 9'd255) ? 8'd255 : s[7:0];
   endfunction

   assign step = {1'b0, speed} + 4'd1;

   assign danger_pos1  = pos_q[0];
   assign danger_pos2  = pos_q[1];
   assign danger_pos3  = pos_q[2];
   assign danger_type1 = type_q[0];
   assign danger_type2 = type_q[1];
   assign danger_type3 = type_q[2];
   assign danger_en1   = en_q[0];
   assign danger_en2   = en_q[1];
   assign danger_en3   = en_q[2];

   // Next-state: move/retire, spawn, gap countdown and LFSR advance per tick
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      lfsr_d  = lfsr_q;
      found   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pos_d[i]  = pos_q[i];
         type_d[i] = type_q[i];
         en_d[i]   = en_q[i];
      end

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = RUN;
               gap_d   = MIN_GAP;
            end
         end
         RUN: begin
            if (!run) begin
               state_d = HOLD;
            end else if (tick) begin
               for (int i = 0; i < 3; i++) begin
                  if (en_q[i]) begin
                     if (pos_q[i] > {5'd0, step}) begin
                        pos_d[i] = pos_q[i] - {5'd0, step};
                     end else begin
                        en_d[i]   = 1'b0;
                        pos_d[i]  = 9'd0;
                        type_d[i] = T_NOTHING;
                     end
                  end
               end
               // Free slots are judged on pre-tick enables, so a slot retired
               // this tick cannot be refilled until the next one.
               if (gap_q == 8'd0) begin
                  for (int i = 0; i < 3; i++) begin
                     if (!en_q[i] && !found) begin
                        found     = 1'b1;
                        en_d[i]   = 1'b1;
                        pos_d[i]  = SPAWN_X;
                        type_d[i] = map_type(lfsr_q[2:0]);
                     end
                  end
               end
               if (found) begin
                  gap_d = sat_gap({1'b0, MIN_GAP} + {4'd0, lfsr_q[4:0]});
               end else if (gap_q != 8'd0) begin
                  gap_d = gap_q - 8'd1;
               end
               lfsr_d = {lfsr_q[14:0],
                         lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end
         end
         HOLD: begin
            if (run) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase

      // clear wins over any tick; the LFSR keeps its state
      if (clear) begin
         state_d = IDLE;
         gap_d   = 8'd0;
         lfsr_d  = lfsr_q;
         for (int i = 0; i < 3; i++) begin
            pos_d[i]  = 9'd0;
            type_d[i] = T_NOTHING;
            en_d[i]   = 1'b0;
         end
      end
   end

   // State, slot, gap and LFSR registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gap_q   <= 8'd0;
         lfsr_q  <= SEED;
         for (int i = 0; i < 3; i++) begin
            pos_q[i]  <= 9'd0;
            type_q[i] <= T_NOTHING;
            en_q[i]   <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
         for (int i = 0; i < 3; i++) begin
            pos_q[i]  <= pos_d[i];
            type_q[i] <= type_d[i];
            en_q[i]   <= en_d[i];
         end
      end
   end

endmodule

// File: tb/tb_danger_spawner.sv
// Bench for danger_spawner: table-driven vectors on instance A
// (SEED=1, MIN_GAP=2, speed 0) plus hand sequences on instance B
// (SEED=1, MIN_GAP=0, speed 7) for retirement, deferred spawn and type range.
module tb_danger_spawner;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // instance A signals
   logic       a_tick = 1'b0, a_run = 1'b0, a_clear = 1'b0;
   logic [2:0] a_speed = 3'd0;
   logic [8:0] a_p1, a_p2, a_p3;
   logic [2:0] a_t1, a_t2, a_t3;
   logic       a_e1, a_e2, a_e3;

   // instance B signals
   logic       b_tick = 1'b0, b_run = 1'b0, b_clear = 1'b0;
   logic [2:0] b_speed = 3'd0;
   logic [8:0] b_p1, b_p2, b_p3;
   logic [2:0] b_t1, b_t2, b_t3;
   logic       b_e1, b_e2, b_e3;

   danger_spawner #(.SPAWN_X(9'd397), .MIN_GAP(8'd2), .SEED(16'h0001)) u_a (
      .clk(clk), .rst(rst), .tick(a_tick), .run(a_run), .clear(a_clear),
      .speed(a_speed),
      .danger_pos1(a_p1), .danger_pos2(a_p2), .danger_pos3(a_p3),
      .danger_type1(a_t1), .danger_type2(a_t2), .danger_type3(a_t3),
      .danger_en1(a_e1), .danger_en2(a_e2), .danger_en3(a_e3)
   );

   danger_spawner #(.SPAWN_X(9'd397), .MIN_GAP(8'd0), .SEED(16'h0001)) u_b (
      .clk(clk), .rst(rst), .tick(b_tick), .run(b_run), .clear(b_clear),
      .speed(b_speed),
      .danger_pos1(b_p1), .danger_pos2(b_p2), .danger_pos3(b_p3),
      .danger_type1(b_t1), .danger_type2(b_t2), .danger_type3(b_t3),
      .danger_en1(b_e1), .danger_en2(b_e2), .danger_en3(b_e3)
   );

   // Types expected from LFSR low bits 0 and 1 depend on the bird option
`ifdef DANGER_BIRD_EN
   localparam logic [2:0] TY0 = 3'd0;
   localparam logic [2:0] TY1 = 3'd1;
`else
   localparam logic [2:0] TY0 = 3'd2;
   localparam logic [2:0] TY1 = 3'd4;
`endif

   typedef struct {
      logic       tick;
      logic       run;
      logic       clear;
      logic [2:0] en;      // {en3, en2, en1}
      logic [8:0] p1, p2, p3;
      logic [2:0] t1, t2, t3;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic void add(input logic tk, input logic rn, input logic cl,
                               input logic [2:0] en,
                               input logic [8:0] p1, input logic [2:0] t1,
                               input logic [8:0] p2, input logic [2:0] t2,
                               input logic [8:0] p3, input logic [2:0] t3);
      vec_t v;
      v.tick = tk; v.run = rn; v.clear = cl; v.en = en;
      v.p1 = p1; v.p2 = p2; v.p3 = p3;
      v.t1 = t1; v.t2 = t2; v.t3 = t3;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [38:0] pack_a();
      return {a_e3, a_e2, a_e1, a_p1, a_p2, a_p3, a_t1, a_t2, a_t3};
   endfunction

   function automatic logic [38:0] pack_b();
      return {b_e3, b_e2, b_e1, b_p1, b_p2, b_p3, b_t1, b_t2, b_t3};
   endfunction

   localparam logic [38:0] EMPTY = {3'b000, 9'd0, 9'd0, 9'd0, 3'd5, 3'd5, 3'd5};

   task automatic b_tick1();
      @(negedge clk);
      b_tick = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int spawns;
   int bad;

   initial begin
      // ---- vector table for instance A ----
      for (int i = 0; i < 5; i++)               // IDLE, run low: ticks ignored
         add(1, 0, 0, 3'b000, 0, 5, 0, 5, 0, 5);
      add(0, 1, 0, 3'b000, 0, 5, 0, 5, 0, 5);   // IDLE -> RUN, gap = 2
      add(1, 1, 0, 3'b000, 0, 5, 0, 5, 0, 5);   // tick 1: gap 2 -> 1
      add(1, 1, 0, 3'b000, 0, 5, 0, 5, 0, 5);   // tick 2: gap 1 -> 0
      add(1, 1, 0, 3'b001, 397, 4, 0, 5, 0, 5); // tick 3: lfsr 0x0004 -> type 4
      for (int t = 4; t <= 9; t++)              // slot1 scrolls 1 px per tick
         add(1, 1, 0, 3'b001, 9'(400 - t), 4, 0, 5, 0, 5);
      add(1, 1, 0, 3'b011, 390, 4, 397, TY0, 0, 5);  // tick 10: lfsr 0x0200
      add(1, 1, 0, 3'b011, 389, 4, 396, TY0, 0, 5);
      add(1, 1, 0, 3'b011, 388, 4, 395, TY0, 0, 5);
      add(1, 1, 0, 3'b111, 387, 4, 394, TY0, 397, 2); // tick 13: lfsr 0x1002
      for (int i = 0; i < 20; i++)              // run low: everything frozen
         add(1, 0, 0, 3'b111, 387, 4, 394, TY0, 397, 2);
      add(1, 0, 1, 3'b000, 0, 5, 0, 5, 0, 5);   // clear beats tick
      for (int i = 0; i < 3; i++)               // back in IDLE
         add(1, 0, 0, 3'b000, 0, 5, 0, 5, 0, 5);

      // ---- reset ----
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_a", 64'(pack_a()), 64'(EMPTY));
      chk("reset_b", 64'(pack_b()), 64'(EMPTY));
      @(negedge clk);
      rst = 1'b1;

      // ---- apply vector table ----
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         a_tick  = vecs[i].tick;
         a_run   = vecs[i].run;
         a_clear = vecs[i].clear;
         @(posedge clk);
         #1;
         chk($sformatf("vecA[%0d]", i), 64'(pack_a()),
             64'({vecs[i].en, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                  vecs[i].t1, vecs[i].t2, vecs[i].t3}));
      end
      @(negedge clk);
      a_tick = 1'b0; a_clear = 1'b0; a_run = 1'b0;

      // ---- instance B: step 8, MIN_GAP 0 ----
      b_run = 1'b1;
      b_speed = 3'd7;
      @(posedge clk);                           // IDLE -> RUN, gap = 0
      #1;
      for (int t = 1; t <= 52; t++) begin
         b_tick1();
         case (t)
            1:  chk("b_t1_spawn", {b_e3, b_e2, b_e1, b_p1, b_t1},
                    {3'b001, 9'd397, TY1});
            2:  chk("b_t2_gap", {b_e3, b_e2, b_e1, b_p1}, {3'b001, 9'd389});
            3:  chk("b_t3_spawn", {b_e3, b_e2, b_e1, b_p1, b_p2, b_t2},
                    {3'b011, 9'd381, 9'd397, 3'd4});
            7:  chk("b_t7_wait", {b_e3, b_e2, b_e1}, 3'b011);
            8:  chk("b_t8_spawn", {b_e3, b_e2, b_e1, b_p3, b_t3},
                    {3'b111, 9'd397, TY0});
            50: chk("b_t50_pos5", {b_e1, b_p1}, {1'b1, 9'd5});
            51: chk("b_t51_retire", {b_e3, b_e2, b_e1, b_p1, b_t1, b_p2},
                    {3'b110, 9'd0, 3'd5, 9'd13});
            52: chk("b_t52_respawn", {b_e3, b_e2, b_e1, b_p1, b_p2},
                    {3'b111, 9'd397, 9'd5});
            default: if (t > 8 && t < 50)
               chk($sformatf("b_full_t%0d", t), {b_e3, b_e2, b_e1}, 3'b111);
         endcase
      end

      // ---- long run: spawned types stay within the allowed set ----
      spawns = 0;
      bad = 0;
      for (int t = 0; t < 40000 && spawns < 1000; t++) begin
         b_tick1();
         if (b_e1 && b_p1 == 9'd397) begin
            spawns++;
`ifdef DANGER_BIRD_EN
            if (b_t1 > 3'd4) bad++;
`else
            if (b_t1 < 3'd2 || b_t1 > 3'd4) bad++;
`endif
         end
         if (b_e2 && b_p2 == 9'd397) begin
            spawns++;
`ifdef DANGER_BIRD_EN
            if (b_t2 > 3'd4) bad++;
`else
            if (b_t2 < 3'd2 || b_t2 > 3'd4) bad++;
`endif
         end
         if (b_e3 && b_p3 == 9'd397) begin
            spawns++;
`ifdef DANGER_BIRD_EN
            if (b_t3 > 3'd4) bad++;
`else
            if (b_t3 < 3'd2 || b_t3 > 3'd4) bad++;
`endif
         end
      end
      chk("spawn_count_reached", 64'(spawns >= 1000), 64'd1);
      chk("spawn_type_range", 64'(bad), 64'd0);
      chk("b_busy_before_reset", 64'(b_e1 | b_e2 | b_e3), 64'd1);

      // ---- asynchronous reset mid-game ----
      @(negedge clk);
      b_tick = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_b", 64'(pack_b()), 64'(EMPTY));
      chk("async_reset_a", 64'(pack_a()), 64'(EMPTY));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
